// File: rtl/mux_arb_pkg.sv
// Shared types for the two-source round-robin burst arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  // Source id; also the encoding of the sel output.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Grant state that corresponds to a given source id.
  function automatic state_e gnt_state(input logic src);
    return (src == SRC_B) ? GNT_B : GNT_A;
  endfunction

endpackage

// File: rtl/mux_arb_fsm.sv
// Grant sequencer: tracks the owner of the shared channel, the round-robin
// history and the beat count of the current burst.
//
//   state | meaning
//   IDLE  | no grant; arbitrate between pending requests
//   GNT_A | source A owns the channel until end of burst
//   GNT_B | source B owns the channel until end of burst
module mux_arb_fsm
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  input  logic xfer,
  input  logic xfer_last,
  output logic sel,
  output logic busy,
  output logic end_of_burst
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             cur_src;
  logic             other_valid;

  assign cur_src      = (state_q == GNT_B) ? SRC_B : SRC_A;
  assign other_valid  = (state_q == GNT_B) ? a_valid : b_valid;
  // A burst ends on the source's own last flag or when the beat limit is hit.
  assign end_of_burst = xfer && (xfer_last || (beat_cnt_q == CNT_MAX));
  assign sel          = (state_q == GNT_B);
  assign busy         = (state_q != IDLE);

  // Next-state, round-robin history and beat counter.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (a_valid && b_valid) begin
          state_d = gnt_state(~last_gnt_q);
        end else if (a_valid) begin
          state_d = GNT_A;
        end else if (b_valid) begin
          state_d = GNT_B;
        end
      end
      GNT_A, GNT_B: begin
        if (end_of_burst) begin
          // The releasing source never re-grants itself directly.
          last_gnt_d = cur_src;
          beat_cnt_d = '0;
          state_d    = other_valid ? gnt_state(~cur_src) : IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; the round-robin history favours A after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= SRC_B;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/mux_arb.sv
// Two-source round-robin arbiter with burst-granular grants and a one-entry
// registered output stage on a valid/ready channel.
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;
  logic             end_of_burst;

  mux_arb_fsm #(
    .MAX_BURST(MAX_BURST)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .b_valid      (b_valid),
    .xfer         (xfer),
    .xfer_last    (gnt_last),
    .sel          (sel),
    .busy         (busy),
    .end_of_burst (end_of_burst)
  );

  // The output register can take a beat when empty or being drained this cycle.
  assign can_load = !out_valid_q || out_ready;
  assign a_ready  = busy && (sel == SRC_A) && can_load;
  assign b_ready  = busy && (sel == SRC_B) && can_load;
  assign xfer     = (a_valid && a_ready) || (b_valid && b_ready);
  assign gnt_data = (sel == SRC_B) ? b_data : a_data;
  assign gnt_last = (sel == SRC_B) ? b_last : a_last;

  // Output stage: load on transfer, otherwise empty once the sink has taken it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_last_d  = gnt_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; reset drops any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
